spi_reg_target: RTL and testbench
=================================

# spi_reg_target

SPI target (slave) that gives an external SPI master access to a small register file. It oversamples `S_CLK`, `CS` and `IN` in the local `CLK` domain, decodes a one-byte command followed by data bytes, and either commits writes to registers or shifts register contents out on `OUT`. It is the responder end of the bus that the `SPI` block drives in master mode (`MS_MODE` high). Register 2 is exported to local logic as `CTRL`.

## Interface
- `ID`, default 8'h5A: read-only value returned at register 0.
- `CLK`  input  1  local clock; must run at ≥ 8× the `S_CLK` frequency.
- `CLR`  input  1  synchronous, active-low reset, sampled on the rising edge of `CLK`.
- `S_CLK`  input  1  SPI clock from the master. Mode 0 (CPOL=0, CPHA=0). Asynchronous to `CLK`.
- `CS`  input  1  chip select, active-low, asynchronous.
- `IN`  input  1  serial data from the master, MSB first.
- `OUT`  inout  1  serial data to the master. Driven while synchronized `CS` is low, `1'bz` otherwise.
- `CTRL`  output  8  current contents of register 2.
- `WR_STB`  output  1  one-cycle pulse for each committed write.
- `WR_ADDR`  output  3  address of the committed write; valid while `WR_STB` is high.
- `WR_DATA`  output  8  data of the committed write; valid while `WR_STB` is high.
- `BUSY`  output  1  high while the state machine is not in IDLE.
- `ERR`  output  1  one-cycle pulse when an illegal command is received.

## Operation
- **Input synchronization:** `S_CLK`, `CS` and `IN` each pass through a 2-flop synchronizer.
- **Edge detection:** edges are detected by comparing the synchronized value with a third registered copy.
  - `IN` is sampled on a detected `S_CLK` rising edge.
  - `OUT` shifts on a detected `S_CLK` falling edge.
- **Bit counter:** `bit_cnt[2:0]` counts `S_CLK` rising edges. A rising edge that takes it from 7 to 0 completes a byte.
- **Register map:**
  - reg0 = `ID`, read-only.
  - reg1 = `WCNT`, read-only; count of committed writes, 8-bit, wraps 255→0.
  - reg2..reg7: read/write, reset to 0.
- **Command byte `C`:**
  - `C[7]`: 1 = write, 0 = read.
  - `C[6:3]` must be 0.
  - `C[2:0]` = start address.
- **States:**
  - **IDLE:** `OUT` is Z. On `CS` falling: clear `bit_cnt`, load `tx = WCNT`, go to CMD.
  - **CMD:** shift the command in. On the byte-complete edge:
    - Legal command: latch address and direction, go to DATA. For a read, load `tx = reg[addr]`.
    - Illegal command: pulse `ERR`, go to DRAIN.
  - **DATA (write):** on each byte-complete edge, commit `rx` to `reg[addr]`, then `addr = addr + 1` (wraps 7→0).
    - Writes to addr 0 or 1 are discarded: no `WR_STB`, `WCNT` unchanged.
    - Writes to addr 2..7: pulse `WR_STB`, increment `WCNT`.
  - **DATA (read):** on each byte-complete edge, `addr = addr + 1` (wraps), then load `tx = reg[addr]`. Incoming bits are ignored.
  - **DRAIN:** `OUT` is driven 0. Stays until `CS` rises.
- **Serial output rules:**
  - `OUT = tx[7]` at all times while driven.
  - On a falling edge with `bit_cnt != 0`, shift `tx` left by one.
  - On a falling edge with `bit_cnt == 0`, do not shift. This preserves the MSB that was just loaded.
- **`CS` rising (any state):** go to IDLE the next cycle. A partially received byte is discarded: no commit, no strobe.
- **Reset:**
  - Reset is valid at any time, including mid-transaction.
  - All state returns to IDLE; reg2..reg7 and `WCNT` reset to 0.
  - Output values in reset: `OUT` = Z, `CTRL` = 0, `WR_STB` = 0, `WR_ADDR` = 0, `WR_DATA` = 0, `BUSY` = 0, `ERR` = 0.
- **Simultaneous events:** a local reset overrides everything else. A `CS` rise in the same cycle as a byte-complete edge is not possible, because the master completes a byte before raising `CS`.

## Timing
- **Input latency:** 3 `CLK` cycles from a pin edge to its detected edge.
- **Write latency:** `WR_STB`, `WR_ADDR` and `WR_DATA` assert 1 cycle after the 8th rising edge of a data byte is detected. `CTRL` updates in the same cycle.
- **Read data:** `tx` is loaded in the cycle after the byte-complete detection. Its MSB is on `OUT` before the next `S_CLK` rising edge, given the ≥ 8× clock ratio.
- **`BUSY`:** rises 1 cycle after `CS` falling is detected; falls 1 cycle after `CS` rising is detected.
- **`ERR`:** exactly 1 cycle wide.
- **`WR_STB`:** exactly 1 cycle wide, one pulse per committed byte.
- **Bus release:** `OUT` goes to Z within 4 `CLK` cycles of the `CS` pin rising.

## Test plan
1. **Write, single byte:** command 8'h82, data 8'h3C.
   - Expect `WR_STB` once with `WR_ADDR`=2 and `WR_DATA`=8'h3C.
   - Expect `CTRL`=8'h3C and `WCNT`=1.
2. **Burst read with wrap:** command 8'h06, then 4 dummy bytes, after registers 6 and 7 were written to 8'h11 and 8'h22.
   - Expect `OUT` bytes 8'h11, 8'h22, 8'h5A, then `WCNT`.
   - Expect the byte clocked out during the command byte to equal the prior `WCNT`.
3. **Read-only and wrap on write:** command 8'h87, data 8'hAA, 8'hBB, 8'hCC.
   - Expect a single `WR_STB` (addr 7, 8'hAA); the writes to addr 0 and 1 are discarded.
   - Expect `WCNT` to increase by 1 and reg0 to still read 8'h5A.
4. **Illegal command:** command 8'h48.
   - Expect a single `ERR` pulse and `OUT`=0 for the rest of the frame.
   - Expect no writes.
   - A following legal transaction must work normally.
5. **Aborted byte:** command 8'h83, then `CS` raised after 5 data bits.
   - Expect no `WR_STB`, reg3 unchanged, `BUSY` low, and `OUT` Z within 4 cycles.
6. **Reset mid-burst:** drive `CLR`=0 during the data byte of a write to reg4.
   - Expect all outputs at their reset values, `CTRL`=0 and `WCNT`=0.
   - Expect the next transaction after `CS` cycles high to succeed.

Source files
------------

// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing an 8-entry register file: ID, write counter, six R/W registers.
// All SPI pins are oversampled in the local clock domain; CTRL mirrors register 2.
module spi_reg_target #(
  parameter logic [7:0] ID = 8'h5A
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_s_clk,
  input  logic       i_cs,
  input  logic       i_in,
  inout  wire        o_out,
  output logic [7:0] o_ctrl,
  output logic       o_wr_stb,
  output logic [2:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  output logic       o_err,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic        r_cs_s1, r_cs_s2, r_cs_d;
  logic        r_in_s1, r_in_s2;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx;
  logic [7:0]  r_tx;
  logic [2:0]  r_addr;
  logic        r_dir_wr;
  logic [7:0]  r_wcnt;
  logic [7:0]  r_regs [0:7];
  logic        r_wr_stb;
  logic [2:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_err;

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_cs_fall;
  logic        w_cs_rise;
  logic        w_byte_done;
  logic [7:0]  w_rx_next;
  logic [2:0]  w_addr_inc;
  logic        w_drive;
  logic        w_out_bit;
  logic [7:0]  w_rf [0:7];

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
  assign w_rx_next   = {r_rx[6:0], r_in_s2};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_addr_inc  = r_addr + 3'd1;

  // Read view of the map; entries 0 and 1 of r_regs are never written.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_rf[i] = r_regs[i];
    end
    w_rf[0] = ID;
    w_rf[1] = r_wcnt;
  end

  // The bus is only driven once the FSM has seen the frame start and CS is still low.
  assign w_drive   = ~r_cs_s2 && (r_state != ST_IDLE);
  assign w_out_bit = (r_state == ST_DRAIN) ? 1'b0 : r_tx[7];
  assign o_out     = w_drive ? w_out_bit : 1'bz;

  assign o_ctrl    = r_regs[2];
  assign o_wr_stb  = r_wr_stb;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_err     = r_err;
  assign o_state   = r_state;

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_in_s1   <= 1'b0;
      r_in_s2   <= 1'b0;
    end else begin
      r_sclk_s1 <= i_s_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= i_cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_in_s1   <= i_in;
      r_in_s2   <= r_in_s1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_rx      <= 8'h00;
      r_tx      <= 8'h00;
      r_addr    <= 3'd0;
      r_dir_wr  <= 1'b0;
      r_wcnt    <= 8'h00;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 3'd0;
      r_wr_data <= 8'h00;
      r_err     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_wr_stb <= 1'b0;
      r_err    <= 1'b0;

      if ((r_state == ST_CMD) || (r_state == ST_DATA)) begin
        if (w_sclk_rise) begin
          r_rx      <= w_rx_next;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        // bit_cnt == 0 means a fresh byte was just loaded; keep its MSB on the line.
        if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_bit_cnt <= 3'd0;
            r_tx      <= r_wcnt;
            r_state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_byte_done) begin
            if (w_rx_next[6:3] == 4'd0) begin
              r_addr   <= w_rx_next[2:0];
              r_dir_wr <= w_rx_next[7];
              r_state  <= ST_DATA;
              if (!w_rx_next[7]) begin
                r_tx <= w_rf[w_rx_next[2:0]];
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            r_addr <= w_addr_inc;
            if (r_dir_wr) begin
              if (r_addr >= 3'd2) begin
                r_regs[r_addr] <= w_rx_next;
                r_wr_stb       <= 1'b1;
                r_wr_addr      <= r_addr;
                r_wr_data      <= w_rx_next;
                r_wcnt         <= r_wcnt + 8'd1;
              end
            end else begin
              r_tx <= w_rf[w_addr_inc];
            end
          end
        end
        ST_DRAIN: begin
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_cs_rise) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: a mode-0 SPI master model with hand-computed expected bytes.
module tb_spi_reg_target;

  localparam int HALF = 8;

  logic       clk;
  logic       clr;
  logic       s_clk;
  logic       cs;
  logic       mosi;
  wire        miso;
  logic [7:0] ctrl;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int err_cycles = 0;

  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  logic [7:0]  rx_b [0:7];

  spi_reg_target #(.ID(8'h5A)) dut (
    .i_clk     (clk),
    .i_clr     (clr),
    .i_s_clk   (s_clk),
    .i_cs      (cs),
    .i_in      (mosi),
    .o_out     (miso),
    .o_ctrl    (ctrl),
    .o_wr_stb  (wr_stb),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_busy    (busy),
    .o_err     (err),
    .o_state   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr && wr_stb) got_q.push_back({wr_addr, wr_data});
    if (clr && err) err_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_wr_entry"}, {21'd0, got_q.pop_front()}, {21'd0, exp_q.pop_front()});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic cs_start();
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = v[i];
      repeat (HALF) @(negedge clk);
      r[i] = miso;
      s_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      s_clk = 1'b0;
    end
  endtask

  // bytes are packed first-byte-most-significant
  task automatic xfer(input logic [39:0] bytes, input int n);
    logic [7:0] r;
    cs_start();
    for (int k = 0; k < n; k++) begin
      spi_bits(bytes[39 - 8 * k -: 8], 8, r);
      rx_b[k] = r;
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] r;
    clr  = 1'b0;
    s_clk = 1'b0;
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_out_z", {31'd0, miso === 1'bz}, 32'd1);
    check("rst_ctrl", {24'd0, ctrl}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stb", {31'd0, wr_stb}, 32'd0);
    clr = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single write to reg2
    xfer({8'h82, 8'h3C, 24'h0}, 2);
    exp_q.push_back({3'd2, 8'h3C});
    check_writes("t1");
    check("t1_ctrl", {24'd0, ctrl}, 32'h3C);
    xfer({8'h01, 8'h00, 24'h0}, 2);
    check("t1_cmd_out", {24'd0, rx_b[0]}, 32'h01);
    check("t1_wcnt", {24'd0, rx_b[1]}, 32'h01);

    // 2: burst read wrapping through ID and WCNT
    xfer({8'h86, 8'h11, 8'h22, 16'h0}, 3);
    exp_q.push_back({3'd6, 8'h11});
    exp_q.push_back({3'd7, 8'h22});
    check_writes("t2");
    xfer({8'h06, 32'h0}, 5);
    check("t2_cmd_out", {24'd0, rx_b[0]}, 32'h03);
    check("t2_reg6", {24'd0, rx_b[1]}, 32'h11);
    check("t2_reg7", {24'd0, rx_b[2]}, 32'h22);
    check("t2_reg0", {24'd0, rx_b[3]}, 32'h5A);
    check("t2_reg1", {24'd0, rx_b[4]}, 32'h03);

    // 3: write wraps onto read-only addresses
    xfer({8'h87, 8'hAA, 8'hBB, 8'hCC, 8'h0}, 4);
    exp_q.push_back({3'd7, 8'hAA});
    check_writes("t3");
    xfer({8'h00, 8'h00, 8'h00, 16'h0}, 3);
    check("t3_wcnt_cmd", {24'd0, rx_b[0]}, 32'h04);
    check("t3_id", {24'd0, rx_b[1]}, 32'h5A);
    check("t3_wcnt", {24'd0, rx_b[2]}, 32'h04);
    xfer({8'h07, 8'h00, 24'h0}, 2);
    check("t3_reg7", {24'd0, rx_b[1]}, 32'hAA);

    // 4: illegal command drains, then a legal frame works
    err_cycles = 0;
    xfer({8'h48, 8'hFF, 8'hFF, 16'h0}, 3);
    check("t4_err_pulse", err_cycles, 1);
    check("t4_drain0", {24'd0, rx_b[1]}, 32'h00);
    check("t4_drain1", {24'd0, rx_b[2]}, 32'h00);
    check_writes("t4");
    xfer({8'h83, 8'h5F, 24'h0}, 2);
    exp_q.push_back({3'd3, 8'h5F});
    check_writes("t4b");
    xfer({8'h03, 8'h00, 24'h0}, 2);
    check("t4_wcnt", {24'd0, rx_b[0]}, 32'h05);
    check("t4_reg3", {24'd0, rx_b[1]}, 32'h5F);

    // 5: CS raised mid data byte
    cs_start();
    spi_bits(8'h83, 8, r);
    spi_bits(8'h99, 5, r);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_out_z", {31'd0, miso === 1'bz}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    repeat (2 * HALF) @(negedge clk);
    check_writes("t5");
    xfer({8'h03, 8'h00, 24'h0}, 2);
    check("t5_reg3", {24'd0, rx_b[1]}, 32'h5F);
    check("t5_wcnt", {24'd0, rx_b[0]}, 32'h05);

    // 6: reset in the middle of a write data byte
    cs_start();
    spi_bits(8'h84, 8, r);
    spi_bits(8'h77, 4, r);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_out_z", {31'd0, miso === 1'bz}, 32'd1);
    check("t6_ctrl", {24'd0, ctrl}, 32'h00);
    check("t6_stb", {31'd0, wr_stb}, 32'd0);
    check("t6_addr", {29'd0, wr_addr}, 32'd0);
    check("t6_data", {24'd0, wr_data}, 32'h00);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    clr = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check_writes("t6");
    xfer({8'h01, 8'h00, 24'h0}, 2);
    check("t6_wcnt", {24'd0, rx_b[1]}, 32'h00);
    xfer({8'h84, 8'h77, 24'h0}, 2);
    exp_q.push_back({3'd4, 8'h77});
    check_writes("t6b");
    xfer({8'h04, 8'h00, 24'h0}, 2);
    check("t6_reg4", {24'd0, rx_b[1]}, 32'h77);
    check("t6_wcnt_after", {24'd0, rx_b[0]}, 32'h01);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
